// File: rtl/noc_pkg.sv
// Shared mesh-router constants and types: port numbering, index and credit widths.
package noc_pkg;
    localparam int NPORT        = 5;
    localparam int CREDIT_DEPTH = 4;
    localparam int CW           = $clog2(CREDIT_DEPTH + 1);

    localparam int P_XP    = 0;
    localparam int P_XM    = 1;
    localparam int P_YM    = 2;
    localparam int P_YP    = 3;
    localparam int P_LOCAL = 4;

    typedef logic [2:0]    port_idx_t;
    typedef logic [CW-1:0] credit_t;
endpackage

// File: rtl/wh_switch_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping mod NPORT.
module rr_arbiter #(
    parameter int NPORT = noc_pkg::NPORT
) (
    input  logic [NPORT-1:0] i_req,
    input  logic [2:0]       i_ptr,
    output logic [NPORT-1:0] o_gnt,
    output logic [2:0]       o_idx,
    output logic             o_any
);
    always_comb begin
        int j;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        j     = 0;
        for (int k = 0; k < NPORT; k++) begin
            j = int'(i_ptr) + k;
            if (j >= NPORT) j = j - NPORT;
            if (!o_any && i_req[j]) begin
                o_gnt[j] = 1'b1;
                o_idx    = 3'(j);
                o_any    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/wh_switch_arbiter.sv
// Wormhole switch allocator: per-output round-robin, head-to-tail output locking,
// downstream credit tracking and a sticky protocol-error flag.
module wh_switch_arbiter #(
    parameter int  NPORT        = noc_pkg::NPORT,
    parameter int  CREDIT_DEPTH = noc_pkg::CREDIT_DEPTH,
    localparam int CW           = $clog2(CREDIT_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NPORT-1:0]    req_valid,
    input  logic [NPORT*3-1:0]  req_port,
    input  logic [NPORT-1:0]    req_head,
    input  logic [NPORT-1:0]    req_tail,
    input  logic [NPORT-1:0]    credit_ret,
    output logic [NPORT-1:0]    gnt_in,
    output logic [NPORT-1:0]    xbar_vld,
    output logic [NPORT*3-1:0]  xbar_sel,
    output logic [NPORT-1:0]    out_locked,
    output logic [NPORT*CW-1:0] credit_cnt,
    output logic                proto_err
);
    import noc_pkg::port_idx_t;

    localparam logic [CW-1:0] CMAX = CW'(CREDIT_DEPTH);

    logic [NPORT-1:0]            r_lock;
    port_idx_t                   r_owner [NPORT];
    port_idx_t                   r_ptr   [NPORT];
    logic [CW-1:0]               r_cnt   [NPORT];
    logic                        r_err;

    logic [NPORT-1:0][2:0]       w_port;
    logic [NPORT-1:0][NPORT-1:0] w_req;
    logic [NPORT-1:0][NPORT-1:0] w_arb_gnt;
    logic [NPORT-1:0][2:0]       w_arb_idx;
    logic [NPORT-1:0]            w_arb_any;
    logic [NPORT-1:0]            w_ok;
    logic                        w_err;

    // A locked output only sees its owner's body/tail flits; an unlocked one only heads.
    always_comb begin
        w_req = '0;
        for (int o = 0; o < NPORT; o++) begin
            for (int i = 0; i < NPORT; i++) begin
                if (req_valid[i] && w_port[i] == 3'(o)) begin
                    w_req[o][i] = r_lock[o] ? (r_owner[o] == 3'(i) && !req_head[i])
                                            : req_head[i];
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NPORT; g++) begin : g_out
            assign w_port[g] = req_port[3*g +: 3];

            rr_arbiter #(.NPORT(NPORT)) u_arb (
                .i_req (w_req[g]),
                .i_ptr (r_ptr[g]),
                .o_gnt (w_arb_gnt[g]),
                .o_idx (w_arb_idx[g]),
                .o_any (w_arb_any[g])
            );

            assign w_ok[g]                  = !rst && w_arb_any[g] && (r_cnt[g] != '0);
            assign xbar_vld[g]              = w_ok[g];
            assign xbar_sel[3*g +: 3]       = w_ok[g] ? w_arb_idx[g] : 3'd0;
            assign out_locked[g]            = r_lock[g];
            assign credit_cnt[CW*g +: CW]   = r_cnt[g];
        end
    endgenerate

    always_comb begin
        gnt_in = '0;
        for (int o = 0; o < NPORT; o++) begin
            if (w_ok[o]) gnt_in = gnt_in | w_arb_gnt[o];
        end
    end

    // Offending requests are simply never candidates above; here they only raise the flag.
    always_comb begin
        w_err = 1'b0;
        for (int i = 0; i < NPORT; i++) begin
            if (req_valid[i]) begin
                if (w_port[i] >= 3'(NPORT)) begin
                    w_err = 1'b1;
                end else if (!req_head[i] &&
                             (!r_lock[w_port[i]] || r_owner[w_port[i]] != 3'(i))) begin
                    w_err = 1'b1;
                end else if (req_head[i] && r_lock[w_port[i]] &&
                             r_owner[w_port[i]] == 3'(i)) begin
                    w_err = 1'b1;
                end
            end
        end
        for (int o = 0; o < NPORT; o++) begin
            if (credit_ret[o] && !w_ok[o] && r_cnt[o] == CMAX) w_err = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock <= '0;
            r_err  <= 1'b0;
            for (int o = 0; o < NPORT; o++) begin
                r_owner[o] <= '0;
                r_ptr[o]   <= '0;
                r_cnt[o]   <= CMAX;
            end
        end else begin
            r_err <= r_err | w_err;
            for (int o = 0; o < NPORT; o++) begin
                if (w_ok[o]) begin
                    r_ptr[o] <= (w_arb_idx[o] == 3'(NPORT - 1)) ? 3'd0 : w_arb_idx[o] + 3'd1;
                    if (req_head[w_arb_idx[o]] && !req_tail[w_arb_idx[o]]) begin
                        r_lock[o]  <= 1'b1;
                        r_owner[o] <= w_arb_idx[o];
                    end else if (req_tail[w_arb_idx[o]]) begin
                        r_lock[o]  <= 1'b0;
                    end
                end
                if (w_ok[o] && !credit_ret[o]) begin
                    r_cnt[o] <= r_cnt[o] - 1'b1;
                end else if (!w_ok[o] && credit_ret[o] && r_cnt[o] != CMAX) begin
                    r_cnt[o] <= r_cnt[o] + 1'b1;
                end
            end
        end
    end

    assign proto_err = r_err;
endmodule

// File: tb/tb_wh_switch_arbiter.sv
// Directed scoreboard bench: stimulus queues expected grants, a negedge monitor pops and compares.
module tb_wh_switch_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  req_valid, req_head, req_tail, credit_ret;
    logic [14:0] req_port;
    logic [4:0]  gnt_in, xbar_vld, out_locked;
    logic [14:0] xbar_sel, credit_cnt;
    logic        proto_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0]  gnt;
        logic [4:0]  vld;
        logic [14:0] sel;
    } exp_t;
    exp_t q[$];

    localparam logic [14:0] ALL4 = 15'h4924;

    wh_switch_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_port   (req_port),
        .req_head   (req_head),
        .req_tail   (req_tail),
        .credit_ret (credit_ret),
        .gnt_in     (gnt_in),
        .xbar_vld   (xbar_vld),
        .xbar_sel   (xbar_sel),
        .out_locked (out_locked),
        .credit_cnt (credit_cnt),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    function automatic exp_t g(input int in, input int out);
        exp_t e;
        e = '0;
        e.gnt[in]        = 1'b1;
        e.vld[out]       = 1'b1;
        e.sel[3*out +: 3] = 3'(in);
        return e;
    endfunction

    function automatic logic [14:0] pv(input int p4, input int p3, input int p2,
                                       input int p1, input int p0);
        return {3'(p4), 3'(p3), 3'(p2), 3'(p1), 3'(p0)};
    endfunction

    function automatic logic [31:0] cnt(input int o);
        logic [14:0] c;
        c = credit_cnt;
        return 32'(c[3*o +: 3]);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] v, input logic [14:0] p, input logic [4:0] h,
                         input logic [4:0] t, input logic [4:0] cr);
        req_valid  = v;
        req_port   = p;
        req_head   = h;
        req_tail   = t;
        credit_ret = cr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && (gnt_in != 0 || xbar_vld != 0)) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_grant gnt=%b vld=%b sel=%h", gnt_in, xbar_vld, xbar_sel);
            end else begin
                e = q.pop_front();
                if ({gnt_in, xbar_vld, xbar_sel} !== e) begin
                    errors++;
                    $display("FAIL grant actual gnt=%b vld=%b sel=%h expected gnt=%b vld=%b sel=%h",
                             gnt_in, xbar_vld, xbar_sel, e.gnt, e.vld, e.sel);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset: outputs forced low even with a live request
        rst = 1'b1;
        drive(5'b00001, pv(0,0,0,0,0), 5'b00001, 5'b00001, 0);
        #1;
        chk("rst_gnt", gnt_in, 0);
        chk("rst_vld", xbar_vld, 0);
        tick(); tick();
        drive(0, 0, 0, 0, 0);
        rst = 1'b0;
        chk("rst_locked", out_locked, 0);
        chk("rst_credits", credit_cnt, ALL4);
        chk("rst_err", proto_err, 0);

        // single-flit packet, input 4 -> output 0
        q.push_back(g(4, 0));
        drive(5'b10000, pv(0,0,0,0,0), 5'b10000, 5'b10000, 0);
        tick();
        chk("t1_cnt0", cnt(0), 3);
        chk("t1_lock0", out_locked[0], 0);
        drive(0, 0, 0, 0, 5'b00001);
        tick();
        chk("t1_cnt0_ret", cnt(0), 4);

        // two outputs granted in one cycle; input 1 loses output 2 to input 0
        q.push_back(exp_t'(g(0, 2) | g(3, 0)));
        drive(5'b01011, pv(0,0,0,2,2), 5'b01011, 5'b01011, 0);
        tick();
        q.push_back(g(1, 2));
        drive(5'b00010, pv(0,0,0,2,0), 5'b00010, 5'b00010, 5'b00001);
        tick();
        chk("ta_cnt2", cnt(2), 2);
        chk("ta_cnt0", cnt(0), 4);

        // round robin + lock on output 4
        q.push_back(g(0, 4));
        drive(5'b00111, pv(0,0,4,4,4), 5'b00111, 5'b00100, 5'b10000);
        tick();
        chk("t2_lock_head", out_locked[4], 1);
        for (int k = 0; k < 3; k++) begin
            q.push_back(g(0, 4));
            drive(5'b00111, pv(0,0,4,4,4), 5'b00110, 5'b00100, 5'b10000);
            tick();
            chk("t2_lock_body", out_locked[4], 1);
        end
        q.push_back(g(0, 4));
        drive(5'b00111, pv(0,0,4,4,4), 5'b00110, 5'b00101, 5'b10000);
        tick();
        chk("t2_unlock_tail0", out_locked[4], 0);
        q.push_back(g(1, 4));
        drive(5'b00110, pv(0,0,4,4,0), 5'b00110, 5'b00100, 5'b10000);
        tick();
        chk("t2_lock_in1", out_locked[4], 1);
        q.push_back(g(1, 4));
        drive(5'b00110, pv(0,0,4,4,0), 5'b00100, 5'b00110, 5'b10000);
        tick();
        chk("t2_unlock_tail1", out_locked[4], 0);
        q.push_back(g(2, 4));
        drive(5'b00100, pv(0,0,4,0,0), 5'b00100, 5'b00100, 5'b10000);
        tick();
        chk("t2_lock_in2", out_locked[4], 0);
        chk("t2_cnt4", cnt(4), 4);
        chk("t2_no_err", proto_err, 0);

        // credit exhaustion on output 1
        for (int k = 0; k < 4; k++) begin
            q.push_back(g(0, 1));
            drive(5'b00001, pv(0,0,0,0,1), 5'b00001, 5'b00001, 0);
            tick();
        end
        chk("t3_cnt1_zero", cnt(1), 0);
        #1;
        chk("t3_stall", gnt_in, 0);
        tick();
        drive(5'b00001, pv(0,0,0,0,1), 5'b00001, 5'b00001, 5'b00010);
        #1;
        chk("t3_stall_ret", gnt_in, 0);
        tick();
        chk("t3_cnt1_one", cnt(1), 1);
        q.push_back(g(0, 1));
        drive(5'b00001, pv(0,0,0,0,1), 5'b00001, 5'b00001, 0);
        tick();
        chk("t3_cnt1_after", cnt(1), 0);

        // send+return cancels; return at full saturates and flags
        chk("t4_err_before", proto_err, 0);
        q.push_back(g(2, 2));
        drive(5'b00100, pv(0,0,2,0,0), 5'b00100, 5'b00100, 5'b01100);
        tick();
        chk("t4_cnt2", cnt(2), 2);
        chk("t4_cnt3", cnt(3), 4);
        chk("t4_err", proto_err, 1);

        // body flit to an unlocked output waits and flags
        do_reset();
        chk("t5_err_clear", proto_err, 0);
        drive(5'b01000, pv(0,0,0,0,0), 5'b00000, 5'b00000, 0);
        #1;
        chk("t5_body_nogrant", gnt_in, 0);
        tick();
        #1;
        chk("t5_body_wait", gnt_in, 0);
        tick();
        chk("t5_body_err", proto_err, 1);

        // illegal port number
        do_reset();
        drive(5'b00010, pv(0,0,0,6,0), 5'b00010, 5'b00010, 0);
        #1;
        chk("t5_port6_nogrant", gnt_in, 0);
        tick();
        chk("t5_port6_err", proto_err, 1);
        chk("t5_credits", credit_cnt, ALL4);

        // async reset mid-packet on output 2
        do_reset();
        q.push_back(g(3, 2));
        drive(5'b01000, pv(0,2,0,0,0), 5'b01000, 5'b00000, 0);
        tick();
        chk("t6_locked", out_locked[2], 1);
        q.push_back(g(3, 2));
        drive(5'b01000, pv(0,2,0,0,0), 5'b00000, 5'b00000, 0);
        tick();
        chk("t6_cnt2", cnt(2), 2);
        #1;
        chk("t6_pre_rst_gnt", gnt_in, 5'b01000);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_gnt", gnt_in, 0);
        chk("t6_rst_vld", xbar_vld, 0);
        chk("t6_rst_sel", xbar_sel, 0);
        chk("t6_rst_lock", out_locked, 0);
        chk("t6_rst_cred", credit_cnt, ALL4);
        drive(0, 0, 0, 0, 0);
        tick(); tick();
        rst = 1'b0;
        chk("t6_post_lock", out_locked, 0);
        chk("t6_post_cred", credit_cnt, ALL4);
        q.push_back(g(0, 2));
        drive(5'b00001, pv(0,0,0,0,2), 5'b00001, 5'b00001, 0);
        tick();
        chk("t6_new_head_cnt2", cnt(2), 3);
        drive(0, 0, 0, 0, 0);
        tick();

        chk("sb_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
